chacha_blk_reader: RTL and testbench

//   Downstream consumer of the chacha core's block output. Waits for blk_ready, then pulses rd_blk.

---
 rtl/chacha_blk_reader.sv | 127 ++++++++++++
 tb/tb_chacha_blk_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_blk_reader.sv
// chacha_blk_reader: requests one keystream block from the chacha core, captures
// the fixed-rate byte burst into a local buffer, then drains it as a valid/ready
// byte stream so a back-pressured consumer never stalls the core.
// Optional feature macro: CHACHA_XOR_EN (adds an in_* stream XORed onto the keystream).
module chacha_blk_reader #(
    parameter int BLK_BYTES = 64,
    parameter int IDX_W     = $clog2(BLK_BYTES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blk_ready,
    output logic       rd_blk,
    input  logic [7:0] blk_data,
    input  logic       abort,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       blk_done
`ifdef CHACHA_XOR_EN
    ,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_BYTES - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             abort_pend_q, abort_pend_d;
    logic             blk_done_q, blk_done_d;
    logic             wr_en;
    logic             in_drain;
    logic             xfer;
    logic [7:0]       rd_byte;
    logic [7:0]       blk_mem [BLK_BYTES];

    assign in_drain = (state_q == S_DRAIN);
    assign rd_byte  = blk_mem[idx_q];
    assign rd_blk   = (state_q == S_REQ);
    assign blk_done = blk_done_q;

    // Output stream: data is forced to zero outside DRAIN so reset/idle look clean.
`ifdef CHACHA_XOR_EN
    assign out_valid = in_drain & in_valid;
    assign in_ready  = in_drain & out_ready;
    assign out_data  = in_drain ? (rd_byte ^ in_data) : 8'h00;
`else
    assign out_valid = in_drain;
    assign out_data  = in_drain ? rd_byte : 8'h00;
`endif
    assign out_last = out_valid & (idx_q == IDX_LAST);
    assign xfer     = out_valid & out_ready;

    // Next-state logic for the IDLE -> REQ -> FILL -> DRAIN sequence.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        abort_pend_d = abort_pend_q;
        blk_done_d   = 1'b0;
        wr_en        = 1'b0;
        case (state_q)
            S_IDLE: begin
                idx_d        = '0;
                abort_pend_d = 1'b0;
                if (blk_ready && !abort) state_d = S_REQ;
            end
            S_REQ: begin
                // An abort here still has to ride out the coming burst.
                idx_d        = '0;
                abort_pend_d = abort;
                state_d      = S_FILL;
            end
            S_FILL: begin
                // The core burst cannot be stopped, so abort only marks the block for discard.
                wr_en = 1'b1;
                idx_d = idx_q + 1'b1;
                if (abort) abort_pend_d = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = (abort_pend_q || abort) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (xfer) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        blk_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                if (abort) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            abort_pend_q <= 1'b0;
            blk_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            abort_pend_q <= abort_pend_d;
            blk_done_q   <= blk_done_d;
        end
    end

    // Block buffer; contents are meaningless until a fill completes, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) blk_mem[idx_q] <= blk_data;
    end

endmodule

// File: tb/tb_chacha_blk_reader.sv
// Directed bench for chacha_blk_reader with a small core model driving blk_data.
module tb_chacha_blk_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       blk_ready = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] blk_data = 8'hEE;
    logic       rd_blk, out_valid, out_last, blk_done;
    logic [7:0] out_data;
`ifdef CHACHA_XOR_EN
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pat_mode = 0;
    int core_k = -1;
    bit rd_prev = 1'b0;

    chacha_blk_reader #(.BLK_BYTES(64), .IDX_W(6)) dut (
        .clk(clk), .rst(rst), .blk_ready(blk_ready), .rd_blk(rd_blk),
        .blk_data(blk_data), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .blk_done(blk_done)
`ifdef CHACHA_XOR_EN
        , .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
`endif
    );

    always #5 clk = ~clk;

    // Core model: byte k is presented during the (k+1)-th cycle after the rd_blk cycle.
    always @(negedge clk) begin
        if (core_k >= 0) begin
            core_k = core_k + 1;
            if (core_k >= 64) core_k = -1;
        end
        if (rd_prev) core_k = 0;
        rd_prev = rd_blk;
        if (core_k >= 0) blk_data = (pat_mode == 0) ? 8'(core_k) : 8'd101;
        else             blk_data = 8'hEE;
    end

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_rd(output int t);
        t = -1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rd_blk) begin
                t = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset;
        tick(); tick();
        checks++; if (rd_blk !== 1'b0)    begin failures++; $display("FAIL rst_rd_blk got=%b exp=0", rd_blk); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0)  begin failures++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
        checks++; if (blk_done !== 1'b0)  begin failures++; $display("FAIL rst_blk_done got=%b exp=0", blk_done); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
        rst = 1'b0;
        tick();
        checks++; if (rd_blk !== 1'b0) begin failures++; $display("FAIL idle_no_req got=%b exp=0", rd_blk); end
    endtask

    task automatic test_basic;
        int r, lat;
        pat_mode = 0; out_ready = 1'b1; blk_ready = 1'b1;
        wait_rd(r);
        checks++; if (r < 0) begin failures++; $display("FAIL basic_rd_seen got=%0d exp>=0", r); end
        blk_ready = 1'b0;
        tick();
        checks++; if (rd_blk !== 1'b0) begin failures++; $display("FAIL basic_rd_one_cycle got=%b exp=0", rd_blk); end
        for (int n = 0; n < 100 && !out_valid; n++) tick();
        lat = cyc - r;
        checks++; if (lat != 65) begin failures++; $display("FAIL basic_latency got=%0d exp=65", lat); end
        for (int i = 0; i < 64; i++) begin
            if (i > 0) tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i) || out_last !== (i == 63) || blk_done !== 1'b0) begin
                failures++;
                $display("FAIL basic_byte%0d got v=%b d=%h l=%b dn=%b exp v=1 d=%h l=%b dn=0",
                         i, out_valid, out_data, out_last, blk_done, 8'(i), (i == 63));
            end
        end
        tick();
        checks++; if (blk_done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_done got dn=%b v=%b exp dn=1 v=0", blk_done, out_valid); end
        tick();
        checks++; if (blk_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", blk_done); end
    endtask

    task automatic test_backpressure;
        int r, hs, dc, dones;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        hs = 0; dc = 0; dones = 0;
        pat_mode = 0; out_ready = 1'b0; blk_ready = 1'b1;
        wait_rd(r);
        blk_ready = 1'b0;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (blk_done) begin dones++; break; end
            if (out_valid) begin
                checks++;
                if (out_data !== 8'(hs) || out_last !== (hs == 63)) begin
                    failures++;
                    $display("FAIL bp_byte got d=%h l=%b exp d=%h l=%b", out_data, out_last, 8'(hs), (hs == 63));
                end
                out_ready = pat[dc % 4];
                dc++;
                if (out_ready) hs++;
            end else begin
                out_ready = 1'b0;
            end
        end
        checks++; if (hs != 64)   begin failures++; $display("FAIL bp_handshakes got=%0d exp=64", hs); end
        checks++; if (dones != 1) begin failures++; $display("FAIL bp_done got=%0d exp=1", dones); end
    endtask

    task automatic test_abort;
        int r, r2;
        bit saw_valid;
        saw_valid = 1'b0; r2 = -1;
        pat_mode = 0; out_ready = 1'b1; blk_ready = 1'b1;
        wait_rd(r);
        while (cyc < r + 11) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (out_valid) saw_valid = 1'b1;
            if (rd_blk) begin r2 = cyc; break; end
            tick();
        end
        checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL abort_fill_valid got=%b exp=0", saw_valid); end
        checks++; if (r2 - r != 66) begin failures++; $display("FAIL abort_fill_idle got=%0d exp=66", r2 - r); end
        blk_ready = 1'b0;
        for (int n = 0; n < 100 && !out_valid; n++) tick();
        repeat (5) tick();
        checks++; if (out_data !== 8'h05) begin failures++; $display("FAIL abort_drain_byte got=%h exp=05", out_data); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_drain_valid got=%b exp=0", out_valid); end
        checks++; if (blk_done !== 1'b0)  begin failures++; $display("FAIL abort_drain_done got=%b exp=0", blk_done); end
        tick();
        checks++; if (out_valid !== 1'b0 || rd_blk !== 1'b0) begin failures++; $display("FAIL abort_idle got v=%b rd=%b exp 0 0", out_valid, rd_blk); end
    endtask

    task automatic test_constant;
        int r1, r2, nbytes, bad, dones;
        r1 = -1; r2 = -1; nbytes = 0; bad = 0; dones = 0;
        pat_mode = 1; out_ready = 1'b1; blk_ready = 1'b1;
        for (int n = 0; n < 400 && dones < 2; n++) begin
            tick();
            if (rd_blk) begin
                if (r1 < 0) r1 = cyc;
                else begin r2 = cyc; blk_ready = 1'b0; end
            end
            if (out_valid) begin
                nbytes++;
                if (out_data !== 8'd101) bad++;
            end
            if (blk_done) dones++;
        end
        blk_ready = 1'b0;
        checks++; if (r2 - r1 != 130) begin failures++; $display("FAIL const_rd_gap got=%0d exp=130", r2 - r1); end
        checks++; if (nbytes != 128)  begin failures++; $display("FAIL const_bytes got=%0d exp=128", nbytes); end
        checks++; if (bad != 0)       begin failures++; $display("FAIL const_data got=%0d exp=0", bad); end
        checks++; if (dones != 2)     begin failures++; $display("FAIL const_done got=%0d exp=2", dones); end
    endtask

    task automatic test_reset_mid_drain;
        int r;
        pat_mode = 0; out_ready = 1'b0; blk_ready = 1'b1;
        wait_rd(r);
        blk_ready = 1'b0;
        for (int n = 0; n < 100 && !out_valid; n++) tick();
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || rd_blk !== 1'b0 || out_data !== 8'h00) begin
            failures++; $display("FAIL rst_async got v=%b rd=%b d=%h exp 0 0 00", out_valid, rd_blk, out_data);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || rd_blk !== 1'b0) begin failures++; $display("FAIL rst_release got v=%b rd=%b exp 0 0", out_valid, rd_blk); end
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
        checks++; if (rd_blk !== 1'b1) begin failures++; $display("FAIL rst_idle_req got=%b exp=1", rd_blk); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

`ifdef CHACHA_XOR_EN
    task automatic test_xor;
        int r, hs;
        hs = 0;
        pat_mode = 1; in_data = 8'hFF; in_valid = 1'b0; out_ready = 1'b1; blk_ready = 1'b1;
        wait_rd(r);
        blk_ready = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL xor_in_ready_fill got=%b exp=0", in_ready); end
        while (cyc < r + 65) tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL xor_stall got v=%b ir=%b exp 0 1", out_valid, in_ready); end
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL xor_in_ready_mirror got=%b exp=0", in_ready); end
        for (int n = 0; n < 300; n++) begin
            tick();
            if (blk_done) break;
            in_valid = cyc[0];
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                checks++;
                if (out_data !== 8'h9A) begin failures++; $display("FAIL xor_data got=%h exp=9a", out_data); end
                hs++;
            end
        end
        in_valid = 1'b0;
        checks++; if (hs != 64) begin failures++; $display("FAIL xor_handshakes got=%0d exp=64", hs); end
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL xor_in_ready_idle got=%b exp=0", in_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_constant();
        test_reset_mid_drain();
`ifdef CHACHA_XOR_EN
        test_xor();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
